// File: rtl/cv32e40s_data_obi_responder.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40s_data_obi_responder
// Brief    : OBI data-port responder in front of a 1-cycle-latency SRAM, with
//            in-order response FIFO. Optional integrity via macro
//            CV32E40S_OBI_RESPONDER_INTEGRITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40s_data_obi_responder #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // OBI A channel
    input  logic        req_i,
    input  logic        reqpar_i,
    output logic        gnt_o,
    output logic        gntpar_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  prot_i,
    input  logic [1:0]  memtype_i,
    input  logic        dbg_i,
    input  logic [12:0] achk_i,
    // OBI R channel
    output logic        rvalid_o,
    output logic        rvalidpar_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        exokay_o,
    output logic [4:0]  rchk_o,
    // SRAM backend
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    // control / alerts
    input  logic        resp_stall_i,
    output logic        integrity_err_o,
    output logic        protocol_err_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NS = 1 << PW;

    logic [CW-1:0] oc;
    logic          gnt;
    logic          accept;
    logic          in_range;
    logic          achk_bad;
    logic          good;
    logic [32:0]   addr_ext;
    logic [32:0]   win_lo;
    logic [32:0]   win_hi;

    // Window end in 33 bits so a window touching 2^32 does not wrap to zero.
    assign addr_ext = {1'b0, addr_i};
    assign win_lo   = {1'b0, ADDR_BASE};
    assign win_hi   = win_lo + {1'b0, ADDR_SIZE};
    assign in_range = (addr_ext >= win_lo) && (addr_ext < win_hi);

`ifdef CV32E40S_OBI_RESPONDER_INTEGRITY_EN
    logic [12:0] achk_exp;
    assign achk_exp = {^wdata_i[31:24], ^wdata_i[23:16], ^wdata_i[15:8], ^wdata_i[7:0],
                       ~dbg_i, 1'b0, 1'b0, ~^{be_i, we_i}, ~^{prot_i, memtype_i},
                       ^addr_i[31:24], ^addr_i[23:16], ^addr_i[15:8], ^addr_i[7:0]};
    assign achk_bad = (achk_i != achk_exp);
`else
    logic unused_integrity;
    assign unused_integrity = ^{achk_i, dbg_i, prot_i, memtype_i};
    assign achk_bad = 1'b0;
`endif

    assign gnt    = (oc < CW'(DEPTH));
    assign accept = req_i & gnt;
    assign good   = in_range & ~achk_bad;

    assign gnt_o       = gnt;
    assign gntpar_o    = ~gnt;
    assign mem_req_o   = rst_n & accept & good;
    assign mem_we_o    = we_i;
    assign mem_be_o    = be_i;
    assign mem_addr_o  = addr_i - ADDR_BASE;
    assign mem_wdata_o = wdata_i;

    assign integrity_err_o = rst_n & accept & achk_bad;
    assign protocol_err_o  = rst_n & (req_i == reqpar_i);

    // Pending stage: the transfer accepted last cycle whose SRAM data is on
    // mem_rdata_i now.
    logic pend_valid;
    logic pend_read;
    logic pend_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_read  <= 1'b0;
            pend_err   <= 1'b0;
        end else begin
            pend_valid <= accept;
            pend_read  <= accept & good & ~we_i;
            pend_err   <= accept & ~good;
        end
    end

    logic [32:0]   resp_new;
    logic [32:0]   fifo_mem [NS];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          fifo_empty;
    logic          avail;
    logic          rvalid;
    logic          push;
    logic          pop;
    logic [32:0]   head;

    assign resp_new   = {pend_err, (pend_read ? mem_rdata_i : 32'h0)};
    assign fifo_empty = (cnt == '0);
    assign avail      = ~fifo_empty | pend_valid;
    assign rvalid     = avail & ~resp_stall_i;
    assign head       = fifo_empty ? resp_new : fifo_mem[rd_ptr];
    // A fresh response bypasses the FIFO only when nothing older is queued.
    assign pop        = rvalid & ~fifo_empty;
    assign push       = pend_valid & ~(rvalid & fifo_empty);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= resp_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            oc     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            case ({accept, rvalid})
                2'b10:   oc <= oc + 1'b1;
                2'b01:   oc <= oc - 1'b1;
                default: oc <= oc;
            endcase
        end
    end

    assign rvalid_o    = rvalid;
    assign rvalidpar_o = ~rvalid;
    assign rdata_o     = rvalid ? head[31:0] : 32'h0;
    assign err_o       = rvalid & head[32];
    assign exokay_o    = 1'b0;

`ifdef CV32E40S_OBI_RESPONDER_INTEGRITY_EN
    // Outputs are already zero outside rvalid, so the parities are zero too.
    assign rchk_o = {err_o ^ exokay_o, ^rdata_o[31:24], ^rdata_o[23:16],
                     ^rdata_o[15:8], ^rdata_o[7:0]};
`else
    assign rchk_o = 5'b00000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40s_data_obi_responder.sv
`default_nettype none
// Bench for cv32e40s_data_obi_responder: directed steps plus random traffic,
// checked against a transaction-level model (queue of expected responses).
module tb_cv32e40s_data_obi_responder;

    localparam int unsigned DEPTH     = 2;
    localparam logic [31:0] ADDR_BASE = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_SIZE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, reqpar_i, gnt_o, gntpar_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [2:0]  prot_i;
    logic [1:0]  memtype_i;
    logic        dbg_i;
    logic [12:0] achk_i;
    logic        rvalid_o, rvalidpar_o, err_o, exokay_o;
    logic [31:0] rdata_o;
    logic [4:0]  rchk_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        resp_stall_i;
    logic        integrity_err_o, protocol_err_o;

    cv32e40s_data_obi_responder #(
        .DEPTH(DEPTH), .ADDR_BASE(ADDR_BASE), .ADDR_SIZE(ADDR_SIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req_i), .reqpar_i(reqpar_i), .gnt_o(gnt_o), .gntpar_o(gntpar_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .prot_i(prot_i), .memtype_i(memtype_i), .dbg_i(dbg_i), .achk_i(achk_i),
        .rvalid_o(rvalid_o), .rvalidpar_o(rvalidpar_o), .rdata_o(rdata_o),
        .err_o(err_o), .exokay_o(exokay_o), .rchk_o(rchk_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .resp_stall_i(resp_stall_i),
        .integrity_err_o(integrity_err_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    // SRAM behind the DUT: addressed purely by what the DUT drives.
    logic [31:0] sram [int unsigned];
    always @(posedge clk) begin
        if (mem_req_o) begin
            automatic int unsigned w   = mem_addr_o >> 2;
            automatic logic [31:0] cur = sram.exists(w) ? sram[w] : 32'h0;
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) cur[8*b +: 8] = mem_wdata_o[8*b +: 8];
                sram[w] = cur;
                mem_rdata_i <= $urandom;
            end else begin
                mem_rdata_i <= cur;
            end
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    // Reference model
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;
    resp_t       exp_q[$];
    logic [31:0] ref_mem [int unsigned];
    int          cyc    = 0;
    int          total  = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit in_window(input logic [31:0] a);
        longint unsigned la = a, lb = ADDR_BASE, ls = ADDR_SIZE;
        return (la >= lb) && (la < lb + ls);
    endfunction

    function automatic logic [12:0] achk_of(input logic [31:0] a, input logic [31:0] wd,
                                            input logic we, input logic [3:0] be,
                                            input logic [2:0] pr, input logic [1:0] mt,
                                            input logic dbg);
        logic [12:0] c;
        for (int b = 0; b < 4; b++) begin
            c[9 + b] = ^wd[8*b +: 8];
            c[b]     = ^a[8*b +: 8];
        end
        c[8] = !dbg;
        c[7] = 1'b0;
        c[6] = 1'b0;
        c[5] = ($countones({be, we}) % 2) == 0;
        c[4] = ($countones({pr, mt}) % 2) == 0;
        return c;
    endfunction

    function automatic logic [4:0] rchk_of(input logic [31:0] d, input logic e);
`ifdef CV32E40S_OBI_RESPONDER_INTEGRITY_EN
        return {e, ^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
`else
        return 5'b00000;
`endif
    endfunction

    function automatic bit achk_wrong();
`ifdef CV32E40S_OBI_RESPONDER_INTEGRITY_EN
        return achk_i != achk_of(addr_i, wdata_i, we_i, be_i, prot_i, memtype_i, dbg_i);
`else
        return 1'b0;
`endif
    endfunction

    // Check one cycle at the falling edge, then advance the model.
    task automatic step();
        bit gnt_exp, acc, good, rv_exp;
        resp_t r;
        @(negedge clk);
        gnt_exp = exp_q.size() < DEPTH;
        acc     = req_i && gnt_exp;
        good    = acc && in_window(addr_i) && !achk_wrong();
        chk("gnt", gnt_o, gnt_exp);
        chk("gntpar", gntpar_o, !gnt_exp);
        chk("mem_req", mem_req_o, good);
        if (good) begin
            chk("mem_addr", mem_addr_o, addr_i - ADDR_BASE);
            chk("mem_ctl", {mem_we_o, mem_be_o, mem_wdata_o}, {we_i, be_i, wdata_i});
        end
        chk("integrity_err", integrity_err_o, acc && achk_wrong());
        chk("protocol_err", protocol_err_o, req_i == reqpar_i);
        rv_exp = !resp_stall_i && exp_q.size() > 0 && exp_q[0].cyc < cyc;
        chk("rvalid", rvalid_o, rv_exp);
        chk("rvalidpar", rvalidpar_o, !rv_exp);
        chk("exokay", exokay_o, 1'b0);
        if (rv_exp) begin
            r = exp_q.pop_front();
            chk("rdata", rdata_o, r.data);
            chk("err", err_o, r.err);
            chk("rchk", rchk_o, rchk_of(r.data, r.err));
        end else begin
            chk("idle_r", {rdata_o, err_o, rchk_o}, 38'h0);
        end
        if (acc) begin
            automatic int unsigned w = (addr_i - ADDR_BASE) >> 2;
            automatic logic [31:0] cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            r.cyc = cyc;
            r.err = !good;
            r.data = 32'h0;
            if (good && we_i) begin
                for (int b = 0; b < 4; b++)
                    if (be_i[b]) cur[8*b +: 8] = wdata_i[8*b +: 8];
                ref_mem[w] = cur;
            end else if (good) begin
                r.data = cur;
            end
            exp_q.push_back(r);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
        req_i = 1'b1; reqpar_i = 1'b0;
        we_i = we; addr_i = a; be_i = be; wdata_i = wd;
        prot_i = 3'($urandom); memtype_i = 2'($urandom); dbg_i = 1'($urandom);
        achk_i = achk_of(a, wd, we, be, prot_i, memtype_i, dbg_i);
    endtask

    task automatic idle();
        req_i = 1'b0; reqpar_i = 1'b1;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_gnt"}, {gnt_o, gntpar_o}, 2'b10);
        chk({tag, "_rvalid"}, {rvalid_o, rvalidpar_o}, 2'b01);
        chk({tag, "_r"}, {rdata_o, err_o, rchk_o}, 38'h0);
        chk({tag, "_mem_req"}, mem_req_o, 1'b0);
        chk({tag, "_alerts"}, {integrity_err_o, protocol_err_o}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; resp_stall_i = 1'b0;
        idle(); we_i = 0; addr_i = 0; be_i = 0; wdata_i = 0;
        prot_i = 0; memtype_i = 0; dbg_i = 0; achk_i = 0;
        #1 reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read back with minimum latency
        drive(1'b1, ADDR_BASE + 32'h100, 4'hF, 32'hDEAD_BEEF); step();
        drive(1'b0, ADDR_BASE + 32'h100, 4'hF, 32'h0);         step();
        idle(); step();
        // Partial byte write, read back merged word
        drive(1'b1, ADDR_BASE + 32'h100, 4'b0101, 32'h1122_3344); step();
        drive(1'b0, ADDR_BASE + 32'h100, 4'hF, 32'h0);            step();
        idle(); step();

        // Stall with request held: grants stop at DEPTH, then drain in order
        resp_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, ADDR_BASE + 32'h100 + 32'(i * 4), 4'hF, 32'h0);
            step();
        end
        resp_stall_i = 1'b0; idle();
        repeat (3) step();

        // Window boundaries: one past the end (wraps to 0 in 32 bits), just
        // below the base, and the last word inside
        drive(1'b0, ADDR_BASE + ADDR_SIZE, 4'hF, 32'h0);   step();
        drive(1'b1, ADDR_BASE - 32'h4, 4'hF, 32'h5555_0000); step();
        drive(1'b1, ADDR_BASE + ADDR_SIZE - 32'h4, 4'hF, 32'hA5A5_5A5A); step();
        drive(1'b0, ADDR_BASE + ADDR_SIZE - 32'h4, 4'hF, 32'h0); step();
        idle(); step();

        // Request parity violation for one cycle
        drive(1'b0, ADDR_BASE + 32'h100, 4'hF, 32'h0); reqpar_i = 1'b1; step();
        idle(); step(); step();

`ifdef CV32E40S_OBI_RESPONDER_INTEGRITY_EN
        // Corrupted address check on a write: no memory update, error response
        drive(1'b1, ADDR_BASE + 32'h100, 4'hF, 32'h0BAD_0BAD); achk_i[0] = ~achk_i[0]; step();
        drive(1'b0, ADDR_BASE + 32'h100, 4'hF, 32'h0); step();
        idle(); step();
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            automatic int sel = $urandom_range(0, 9);
            automatic logic [31:0] a = (sel == 0) ? ADDR_BASE + ADDR_SIZE + 32'($urandom_range(0, 3) * 4)
                                     : (sel == 1) ? ADDR_BASE - 32'($urandom_range(1, 4) * 4)
                                     : ADDR_BASE + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) != 0) drive(1'($urandom), a, 4'($urandom), $urandom);
            else idle();
            if ($urandom_range(0, 15) == 0) reqpar_i = req_i;
`ifdef CV32E40S_OBI_RESPONDER_INTEGRITY_EN
            if ($urandom_range(0, 15) == 0) achk_i = achk_i ^ 13'(1 << $urandom_range(0, 12));
`endif
            resp_stall_i = ($urandom_range(0, 2) == 0);
            step();
        end
        idle(); resp_stall_i = 1'b0;
        repeat (4) step();

        // Asynchronous reset with two responses outstanding
        resp_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ADDR_BASE + 32'h100, 4'hF, 32'h0);
            step();
        end
        chk("pre_reset_outstanding", exp_q.size(), 64'd2);
        rst_n = 1'b0;
        #1 reset_outputs("async_reset");
        exp_q.delete();
        @(posedge clk); #1;
        idle(); resp_stall_i = 1'b0; rst_n = 1'b1;
        repeat (4) step();
        drive(1'b0, ADDR_BASE + 32'h100, 4'hF, 32'h0); step();
        idle(); repeat (2) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
